// File: rtl/add_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default width
// and the bit-counter width helper.
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // One bit wider than needed to index N steps, so the counter can reach N without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/add_serial_fa_bit.sv
// One-bit full adder built from gate primitives; the serial adder steps it once per cycle.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;
    logic gen;
    logic pass;

    xor g_prop (prop, x, y);
    xor g_sum  (sum, prop, cin);
    and g_gen  (gen, x, y);
    and g_pass (pass, prop, cin);
    or  g_cout (cout, gen, pass);

endmodule

// File: rtl/add_serial.sv
// Bit-serial N-bit adder: captures operands on start, adds one bit per cycle LSB first,
// then pulses done for one cycle with out, cout and ovf held until the next start.
module add_serial
    import add_serial_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         ovf
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          sum_bit;
    logic          carry_next;
    logic [N-1:0]  out_shifted;

    fa_bit u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (carry_next)
    );

    // The result fills from the MSB end so that after N steps bit 0 lands at out[0].
    always_comb begin
        out_shifted        = out >> 1;
        out_shifted[N-1]   = sum_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    out   <= out_shifted;
                    cnt   <= cnt + CW'(1);
                    // Flags come only from the MSB step; ovf compares carry in and out of it.
                    if (cnt == LAST) begin
                        cout  <= carry_next;
                        ovf   <= carry ^ carry_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial: directed corner cases, random operands,
// back-to-back operation with start held high, and reset mid-operation.
module tb_add_serial;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
    } op_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic         busy;
    logic         done;
    logic [N-1:0] out;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain wide addition; signed overflow when like-signed operands give an opposite-signed sum.
    task automatic model(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                         output logic [N-1:0] eo, output logic ec, output logic ev);
        logic [N:0] full;
        full = {1'b0, ia} + {1'b0, ib} + {{N{1'b0}}, ic};
        eo   = full[N-1:0];
        ec   = full[N];
        ev   = (ia[N-1] == ib[N-1]) && (eo[N-1] != ia[N-1]);
    endtask

    // Starts one addition from IDLE, scrambles a/b/c and keeps start high while busy, then checks results.
    task automatic apply_stimulus(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic);
        logic [N-1:0] eo;
        logic         ec;
        logic         ev;
        int           k;
        int           busy_drops;
        model(ia, ib, ic, eo, ec, ev);
        a = ia; b = ib; c = ic; start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        busy_drops = 0;
        do begin
            if (!busy) busy_drops++;
            a = $urandom; b = $urandom; c = 1'($urandom); start = 1'b1;
            @(posedge clk); #1;
            k++;
        end while (!done && k < N + 4);
        check_output({tag, "_latency"}, 64'(k), 64'(N));
        check_output({tag, "_busy_run"}, 64'(busy_drops), 64'(0));
        check_output({tag, "_busy_done"}, 64'(busy), 64'(1));
        check_output({tag, "_out"}, 64'(out), 64'(eo));
        check_output({tag, "_cout"}, 64'(cout), 64'(ec));
        check_output({tag, "_ovf"}, 64'(ovf), 64'(ev));
        start = 1'b0;
        @(posedge clk); #1;
        check_output({tag, "_done_pulse"}, 64'(done), 64'(0));
        check_output({tag, "_idle_busy"}, 64'(busy), 64'(0));
        check_output({tag, "_hold"}, 64'({ovf, cout, out}), 64'({ev, ec, eo}));
    endtask

    initial begin
        op_t          q[$];
        op_t          op;
        logic [N-1:0] eo;
        logic         ec;
        logic         ev;
        logic         acc;
        int           last_done;
        int           n_done;
        int           done_seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 64'({busy, done, cout, ovf, out}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        apply_stimulus("five_plus_three", 32'd5, 32'd3, 1'b0);
        apply_stimulus("all_ones_plus_one", 32'hFFFF_FFFF, 32'd1, 1'b0);
        apply_stimulus("max_pos_plus_one", 32'h7FFF_FFFF, 32'd1, 1'b0);
        apply_stimulus("ten_minus_three", 32'd10, 32'hFFFF_FFFC, 1'b1);
        apply_stimulus("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 6; i++)
            apply_stimulus($sformatf("random%0d", i), $urandom, $urandom, 1'($urandom));

        // Back-to-back: start held high, fresh operands every cycle, accepted only when idle.
        last_done = -1;
        n_done    = 0;
        for (int cyc = 0; cyc < 4 * (N + 2); cyc++) begin
            a = $urandom; b = $urandom; c = 1'($urandom); start = 1'b1;
            acc = !busy;
            @(posedge clk);
            if (acc) begin
                op.a = a; op.b = b; op.c = c;
                q.push_back(op);
            end
            #1;
            if (done) begin
                n_done++;
                check_output("b2b_queue", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    op = q.pop_front();
                    model(op.a, op.b, op.c, eo, ec, ev);
                    check_output("b2b_result", 64'({ovf, cout, out}), 64'({ev, ec, eo}));
                end
                if (last_done >= 0)
                    check_output("b2b_period", 64'(cyc - last_done), 64'(N + 2));
                last_done = cyc;
            end
        end
        check_output("b2b_count", 64'(n_done), 64'(4));
        check_output("b2b_leftover", 64'(q.size()), 64'(0));
        start = 1'b0;
        @(posedge clk); #1;

        // Reset in the tenth RUN cycle, with start also high, must abandon the operation.
        apply_stimulus("pre_reset", $urandom | 32'h0001_0000, $urandom, 1'b1);
        a = $urandom; b = $urandom; c = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b1; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_done", 64'(done), 64'(0));
        check_output("rst_flags_out", 64'({cout, ovf, out}), 64'(0));
        rst = 1'b0; start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check_output("rst_no_done", 64'(done_seen), 64'(0));
        apply_stimulus("post_reset", $urandom, $urandom, 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 SHALL have parameter N, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only while busy is low.
REQ-005 SHALL have port a  input  N  addend A, captured on accepted start.
REQ-006 SHALL have port b  input  N  addend B, captured on accepted start.
REQ-007 SHALL have port c  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when out, cout and ovf are valid.
REQ-010 SHALL have port out  output  N  sum A+B+c modulo 2^N.
REQ-011 SHALL have port cout  output  1  carry out of bit N-1.
REQ-012 SHALL have port ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE: busy=0, done=0.
- IDLE, start=1: capture a, b and c; clear the bit counter; go to RUN.
REQ-014 In RUN, SHALL process one bit per cycle, LSB first.
- sum bit = a[i]^b[i]^carry.
- new carry = (a[i]&b[i]) | ((a[i]^b[i])&carry).
- Sum bit shifted into the result register from the MSB end.
REQ-015 SHALL leave RUN after exactly N cycles, then enter DONE for exactly one cycle with done=1.
- DONE then returns to IDLE.
REQ-016 Latency SHALL be N+1 cycles from the accepted start edge to the done=1 cycle.
REQ-017 SHALL hold busy=1 in RUN and DONE; busy=0 in IDLE.
REQ-018 SHALL ignore start while busy=1.
- No restart.
- Captured operands are unaffected by a or b changes.
REQ-019 SHALL keep out, cout and ovf stable from the done cycle until the next accepted start.
- The register update at that start may change them.
REQ-020 SHALL accept a new start in the cycle after done, giving back-to-back operation every N+2 cycles.
REQ-021 SHALL set cout and ovf from the bit-(N-1) step only.
- ovf uses the carry before and after that step.
REQ-022 Bit counter SHALL be ceil(log2(N))+1 bits wide and SHALL NOT wrap within an operation.
REQ-023 Results SHALL equal those of the team's combinational N-bit ripple adder for identical a, b and c.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL go to IDLE with:
- busy=0, done=0;
- out=0, cout=0, ovf=0;
- carry and counter cleared.
REQ-025 Reset SHALL take priority over start, including when both are high in the same cycle.
REQ-026 Reset during RUN or DONE SHALL abandon the operation.
- No done pulse is produced for it.

Structure
REQ-027 The shared package SHALL hold:
- the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the default width constant 32.
REQ-028 SHALL use one sub-module, fa_bit: a 1-bit full adder producing sum and carry, built from the team's and/xor/or primitives.
REQ-029 The rest SHALL be the FSM, the operand shift registers, the result shift register and the counter, in add_serial.

Verification
REQ-030 Bench SHALL check: a=5, b=3, c=0 -> done at cycle N+1, out=8, cout=0, ovf=0.
REQ-031 Bench SHALL check: a=32'hFFFFFFFF, b=1, c=0 -> out=0, cout=1, ovf=0.
REQ-032 Bench SHALL check: a=32'h7FFFFFFF, b=1, c=0 -> out=32'h80000000, cout=0, ovf=1.
REQ-033 Bench SHALL check: a=10, b=32'hFFFFFFFC (NOT 3), c=1 -> out=7, cout=1, matching 10-3.
REQ-034 Bench SHALL check: start held high throughout with new a/b each cycle -> operations complete every N+2 cycles, each using the operands captured at its accepted start.
REQ-035 Bench SHALL check: rst pulsed at RUN cycle 10 with start=1 -> IDLE next cycle, all outputs 0, no done; the following start completes normally.
